// File: rtl/ila_cmd_frame.sv
// rtl/ila_cmd_frame.sv - ILA host command framer: header + payload collection with valid/ack hand-off.
// Optional inter-byte timeout in PAYLOAD is enabled by defining ILA_CMD_TIMEOUT_EN.
module ila_cmd_frame #(
    parameter int MAX_PAYLOAD    = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_rx_valid,
    input  logic [7:0]               i_rx_byte,
    input  logic                     i_frame_ack,
    output logic                     o_wr_en,
    output logic [3:0]               o_cmd_nib,
    output logic [3:0]               o_payload_len,
    output logic [8*MAX_PAYLOAD-1:0] o_payload,
    output logic                     o_frame_valid,
    output logic                     o_err,
    output logic                     o_overrun
);

    localparam int CW = $clog2(MAX_PAYLOAD + 1);

    typedef enum logic [1:0] {
        IDLE,
        PAYLOAD,
        DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] count;

`ifdef ILA_CMD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    logic [TW-1:0] tmo;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= IDLE;
            count         <= '0;
            o_wr_en       <= 1'b0;
            o_cmd_nib     <= 4'd0;
            o_payload_len <= 4'd0;
            o_payload     <= '0;
            o_frame_valid <= 1'b0;
            o_err         <= 1'b0;
            o_overrun     <= 1'b0;
`ifdef ILA_CMD_TIMEOUT_EN
            tmo           <= '0;
`endif
        end else begin
            o_err     <= 1'b0;
            o_overrun <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_rx_valid) begin
                        o_cmd_nib     <= i_rx_byte[7:4];
                        o_payload_len <= i_rx_byte[3:0];
                        o_payload     <= '0;
                        if (i_rx_byte[3:0] > 4'(MAX_PAYLOAD)) begin
                            o_err <= 1'b1;
                        end else if (i_rx_byte[3:0] == 4'd0) begin
                            state         <= DONE;
                            o_wr_en       <= 1'b1;
                            o_frame_valid <= 1'b1;
                        end else begin
                            state   <= PAYLOAD;
                            o_wr_en <= 1'b1;
                            count   <= '0;
`ifdef ILA_CMD_TIMEOUT_EN
                            tmo     <= '0;
`endif
                        end
                    end
                end
                PAYLOAD: begin
                    if (i_rx_valid) begin
                        o_payload[8*count +: 8] <= i_rx_byte;
                        count                   <= count + 1'b1;
`ifdef ILA_CMD_TIMEOUT_EN
                        tmo                     <= '0;
`endif
                        if (4'(count) == o_payload_len - 4'd1) begin
                            state         <= DONE;
                            o_frame_valid <= 1'b1;
                        end
`ifdef ILA_CMD_TIMEOUT_EN
                    end else if (tmo == TW'(TIMEOUT_CYCLES - 1)) begin
                        // Silence on the line: abandon the frame and let the host resync on a header.
                        state   <= IDLE;
                        o_wr_en <= 1'b0;
                        o_err   <= 1'b1;
                        tmo     <= '0;
                    end else begin
                        tmo <= tmo + 1'b1;
`endif
                    end
                end
                DONE: begin
                    // Bytes arriving while a frame is held are never queued.
                    if (i_rx_valid) begin
                        o_overrun <= 1'b1;
                    end
                    if (i_frame_ack) begin
                        state         <= IDLE;
                        o_wr_en       <= 1'b0;
                        o_frame_valid <= 1'b0;
                    end
                end
                default: begin
                    state         <= IDLE;
                    o_wr_en       <= 1'b0;
                    o_frame_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ila_cmd_frame.sv
// tb/tb_ila_cmd_frame.sv - directed and randomized bench for ila_cmd_frame against a frame-level model.
module tb_ila_cmd_frame;

    localparam int MAXP = 8;
    localparam int TMO  = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_byte = 8'd0;
    logic              frame_ack = 1'b0;
    logic              wr_en;
    logic [3:0]        cmd_nib;
    logic [3:0]        payload_len;
    logic [8*MAXP-1:0] payload;
    logic              frame_valid;
    logic              err;
    logic              overrun;

    int tests  = 0;
    int failed = 0;

    ila_cmd_frame #(.MAX_PAYLOAD(MAXP), .TIMEOUT_CYCLES(TMO)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_rx_valid    (rx_valid),
        .i_rx_byte     (rx_byte),
        .i_frame_ack   (frame_ack),
        .o_wr_en       (wr_en),
        .o_cmd_nib     (cmd_nib),
        .o_payload_len (payload_len),
        .o_payload     (payload),
        .o_frame_valid (frame_valid),
        .o_err         (err),
        .o_overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic ack(input logic with_rx, input logic [7:0] b);
        frame_ack = 1'b1;
        rx_valid  = with_rx;
        rx_byte   = b;
        @(negedge clk);
        frame_ack = 1'b0;
        rx_valid  = 1'b0;
    endtask

    initial begin
        logic [63:0] exp;
        logic [7:0]  h, b;
        logic        ov;
        int          len, n;

        // Reset state
        @(negedge clk);
        check("rst_wr_en", 64'(wr_en), 0);
        check("rst_cmd", 64'(cmd_nib), 0);
        check("rst_len", 64'(payload_len), 0);
        check("rst_payload", payload, 0);
        check("rst_fv", 64'({frame_valid, err, overrun}), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Asynchronous reset in the middle of a frame
        pulse(8'h32);
        pulse(8'hAA);
        check("mid_wr_en", 64'(wr_en), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_wr_en", 64'(wr_en), 0);
        check("async_cmd", 64'(cmd_nib), 0);
        check("async_payload", payload, 0);
        check("async_misc", 64'({payload_len, frame_valid, err, overrun}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulse(8'h32);
        pulse(8'hAA);
        pulse(8'hBB);
        check("rr_fv", 64'(frame_valid), 1);
        check("rr_cmd", 64'(cmd_nib), 3);
        check("rr_payload", 64'(payload[15:0]), 64'hBBAA);
        ack(1'b0, 8'h00);

        // Normal two-byte frame, back-to-back bytes
        pulse(8'h52);
        check("nf_wr_en", 64'(wr_en), 1);
        check("nf_fv_early", 64'(frame_valid), 0);
        pulse(8'h11);
        check("nf_fv_mid", 64'(frame_valid), 0);
        pulse(8'h22);
        check("nf_fv", 64'(frame_valid), 1);
        check("nf_cmd", 64'(cmd_nib), 5);
        check("nf_len", 64'(payload_len), 2);
        check("nf_payload", 64'(payload[15:0]), 64'h2211);
        ack(1'b0, 8'h00);
        check("nf_ack", 64'({wr_en, frame_valid}), 0);

        // Zero-length frame held without ack
        pulse(8'hA0);
        check("zl_fv", 64'(frame_valid), 1);
        check("zl_payload", payload, 0);
        repeat (3) @(negedge clk);
        check("zl_hold", 64'({wr_en, frame_valid, cmd_nib, payload_len}), 64'({1'b1, 1'b1, 4'hA, 4'h0}));
        check("zl_hold_payload", payload, 0);
        ack(1'b0, 8'h00);

        // Length error, following byte is a header
        pulse(8'h49);
        check("le_err", 64'(err), 1);
        check("le_wr_en", 64'(wr_en), 0);
        pulse(8'h41);
        check("le_err_once", 64'(err), 0);
        check("le_next_hdr", 64'({wr_en, cmd_nib}), 64'({1'b1, 4'h4}));
        pulse(8'h5A);
        check("le_next_fv", 64'(frame_valid), 1);

        // Overrun on the ack cycle; dropped byte is not a header
        ack(1'b1, 8'h77);
        check("ov_pulse", 64'(overrun), 1);
        check("ov_idle", 64'({wr_en, frame_valid}), 0);
        @(negedge clk);
        check("ov_not_hdr", 64'({wr_en, overrun}), 0);

`ifdef ILA_CMD_TIMEOUT_EN
        // Timeout after silence, measured from the last accepted byte
        pulse(8'h13);
        pulse(8'h01);
        n = 0;
        while (!err && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("to_cycles", 64'(n), TMO);
        check("to_wr_en", 64'(wr_en), 0);
        // A byte exactly on the expiry edge wins
        pulse(8'h13);
        pulse(8'h01);
        repeat (TMO - 1) @(negedge clk);
        pulse(8'h02);
        check("to_edge_err", 64'(err), 0);
        check("to_edge_state", 64'({wr_en, frame_valid}), 64'(2'b10));
        pulse(8'h03);
        check("to_edge_fv", 64'(frame_valid), 1);
        ack(1'b0, 8'h00);
`endif

        // Randomized frames against the frame-level model
        for (int f = 0; f < 60; f++) begin
            h   = 8'($urandom);
            len = int'(h[3:0]);
            pulse(h);
            if (len > MAXP) begin
                check("r_err", 64'({err, wr_en}), 64'(2'b10));
                @(negedge clk);
                check("r_err_once", 64'(err), 0);
                continue;
            end
            check("r_hdr", 64'({wr_en, cmd_nib, payload_len}), 64'({1'b1, h}));
            exp = 0;
            for (int k = 0; k < len; k++) begin
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk);
                    check("r_gap", 64'({wr_en, frame_valid, err}), 64'(3'b100));
                end
                b = 8'($urandom);
                exp = exp | (64'(b) << (8 * k));
                pulse(b);
            end
            check("r_fv", 64'(frame_valid), 1);
            check("r_payload", payload, exp);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if ($urandom_range(0, 1) == 1) begin
                pulse(8'($urandom));
                check("r_overrun", 64'(overrun), 1);
            end
            check("r_stable", 64'({wr_en, frame_valid, cmd_nib, payload_len}), 64'({2'b11, h}));
            check("r_stable_payload", payload, exp);
            ov = 1'($urandom);
            ack(ov, 8'($urandom));
            check("r_ack", 64'({wr_en, frame_valid, overrun}), 64'({2'b00, ov}));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/ila_cmd_frame.md
# ila_cmd_frame

Command framer for the ILA control path. It sits between the UART byte receiver and the bank of command-nibble matchers. It parses each host frame, which is a header byte followed by 0–15 payload bytes. It drives the command nibble and the write-enable that the matchers sample. It presents the collected payload to the register/trigger logic behind a valid/ack handshake.

## Interface
- `MAX_PAYLOAD`, default 8: maximum payload bytes stored; legal range 1..15.
- `TIMEOUT_CYCLES`, default 100000: inter-byte timeout in `i_clk` cycles; must be ≥ 2; used only with `ILA_CMD_TIMEOUT_EN`.
- `i_clk`, input, 1: sole clock; everything is rising-edge.
- `i_rst_n`, input, 1: asynchronous active-low reset.
- `i_rx_valid`, input, 1: one-cycle strobe; `i_rx_byte` is valid this cycle.
- `i_rx_byte`, input, 8: received byte.
- `i_frame_ack`, input, 1: consumer accepts the presented frame.
- `o_wr_en`, output, 1: frame in progress or held; feeds matcher write-enable.
- `o_cmd_nib`, output, 4: header bits [7:4]; feeds matcher nibble input.
- `o_payload_len`, output, 4: header bits [3:0] of the current frame.
- `o_payload`, output, 8*MAX_PAYLOAD: payload; byte k is at bits [8k+7:8k], first byte at k=0.
- `o_frame_valid`, output, 1: complete frame presented.
- `o_err`, output, 1: one-cycle pulse on length error or timeout.
- `o_overrun`, output, 1: one-cycle pulse when a byte is dropped in DONE.

## Operation
- States: IDLE, PAYLOAD, DONE.
- IDLE:
  - `o_wr_en`=0 and `o_frame_valid`=0.
  - On `i_rx_valid`, latch `o_cmd_nib`=byte[7:4], `o_payload_len`=byte[3:0] and clear `o_payload` to 0.
  - If len > MAX_PAYLOAD: pulse `o_err` and stay in IDLE; `o_wr_en` stays 0.
  - If len == 0: go to DONE.
  - Otherwise: go to PAYLOAD with byte counter = 0.
- PAYLOAD:
  - `o_wr_en`=1.
  - Each `i_rx_valid` writes the byte into slot[counter] and increments the counter.
  - When the byte written is number len (counter == len-1), go to DONE.
  - Counter width is $clog2(MAX_PAYLOAD+1); it never wraps because len ≤ MAX_PAYLOAD.
- DONE:
  - `o_wr_en`=1 and `o_frame_valid`=1.
  - Outputs are stable until ack.
  - `i_frame_ack`=1 → go to IDLE.
  - Any `i_rx_valid` in DONE is dropped and pulses `o_overrun`, including in the ack cycle.
- `i_frame_ack` outside DONE is ignored.
- `o_cmd_nib` and `o_payload_len` hold their last values in IDLE.
- Reset, asynchronous and valid in any state:
  - State → IDLE.
  - All outputs 0: `o_wr_en`, `o_cmd_nib`, `o_payload_len`, `o_payload`, `o_frame_valid`, `o_err`, `o_overrun`.
  - Counters → 0.
  - A frame in progress at reset is lost; no error is reported.

## Timing
- Header accepted at edge N:
  - `o_wr_en` and `o_cmd_nib` are valid from cycle N+1.
  - The matchers' `o_hold` follows at N+2.
- Last payload byte accepted at edge M: `o_frame_valid`=1 from cycle M+1.
- Zero-length frame: `o_frame_valid`=1 one cycle after the header.
- Ack sampled at edge A: `o_wr_en` and `o_frame_valid` are 0 from cycle A+1.
- A header can be accepted at edge A+1 at the earliest.
- `o_err` and `o_overrun` are high for exactly one cycle, the cycle after the triggering edge.
- Back-to-back `i_rx_valid` on every cycle is supported in IDLE and PAYLOAD.

## Configuration
- `ILA_CMD_TIMEOUT_EN` defined:
  - A timeout counter of width $clog2(TIMEOUT_CYCLES) runs in PAYLOAD.
  - It clears on entry to PAYLOAD and on every accepted byte.
  - Reaching TIMEOUT_CYCLES-1 with no byte pulses `o_err`, returns to IDLE and drops `o_wr_en` on the next cycle.
  - A byte arriving on the same edge as expiry takes priority; the counter clears and no error is raised.
- Undefined: no counter is implemented; PAYLOAD waits indefinitely for bytes.

## Test plan
- Reset mid-frame: assert `i_rst_n`=0 asynchronously in PAYLOAD → all outputs 0 immediately; after release, header 0x32, 0xAA, 0xBB → `o_frame_valid`=1, `o_cmd_nib`=3, `o_payload[15:0]`=0xBBAA.
- Normal frame: header 0x52, then 0x11 and 0x22 on consecutive cycles → `o_wr_en`=1 one cycle after the header; `o_frame_valid`=1 one cycle after 0x22; `o_cmd_nib`=5, `o_payload_len`=2, `o_payload[15:0]`=0x2211; ack → both low next cycle.
- Zero-length frame: header 0xA0 → `o_frame_valid`=1 at the next cycle with `o_payload`=0; hold 3 cycles without ack → outputs unchanged.
- Length error, MAX_PAYLOAD=8: header 0x49 → `o_err` pulses for 1 cycle, `o_wr_en` stays 0; next byte 0x41 is treated as a header.
- Overrun: in DONE, `i_rx_valid` with 0x77 on the same cycle as ack → `o_overrun` pulses, state goes to IDLE, 0x77 is not taken as a header.
- Timeout (`ILA_CMD_TIMEOUT_EN`, TIMEOUT_CYCLES=16): header 0x13, one byte, then silence → `o_err` 16 cycles after that byte, `o_wr_en`=0 next cycle; a variant with a byte exactly on the expiry edge → no error.
